dmem_bus: RTL and testbench
===========================

Name: dmem_bus

Overview:
Second-generation data memory for the test processor. It replaces the always-ready word-only store with a request/response interface. The block supports byte, half and word (and dword when WIDTH=64) loads and stores, with sign or zero extension on loads. It detects misaligned accesses and inserts a programmable number of wait states, so the core's stall logic can be exercised. It sits between the core's memory stage and the data RAM.

Parameters:
WIDTH, 32, data/address width in bits; legal values 32 or 64
SIZE, 64, depth in WIDTH-bit words; power of two
WAIT, 0, extra wait cycles per access; legal range 0..7

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
we  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word, 11 dword (dword only when WIDTH=64)
unsigned_ld  in  1  zero-extend loads when 1; sign-extend when 0
a  in  WIDTH  byte address
wd  in  WIDTH  store data, right-justified in the LSBs
rsp_valid  out  1  one-cycle response pulse
rd  out  WIDTH  load data, extended; 0 for stores and faults
misalign  out  1  fault flag; meaningful only while rsp_valid=1

Behaviour:
- Clock and reset: one clock is used. Reset is synchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rd=0, misalign=0, wait counter=0. RAM contents are not reset.
- Address decode: ALSB = log2(WIDTH/8). Word index = a[ALSB+log2(SIZE)-1 : ALSB]. Upper address bits are ignored, so addresses wrap modulo SIZE*WIDTH/8 bytes. Lane = a[ALSB-1:0].
- FSM states:
  - IDLE: req_ready=1. A request is accepted on an edge where req_valid=1. At that edge, we/size/unsigned_ld/a/wd are captured, cnt is set to WAIT, and state goes to BUSY.
  - BUSY: req_ready=0. If cnt!=0, cnt decrements. If cnt==0, the access is performed on that edge and state goes to RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle, then state returns to IDLE.
- Latency: for a request accepted at edge E0, rsp_valid is high during the cycle between edges E0+WAIT+1 and E0+WAIT+2. There is no backpressure on the response. Peak throughput is one access per WAIT+3 cycles.
- Misalignment: an access is misaligned when the lane is not a multiple of the access bytes (half: a[0]!=0; word: a[1:0]!=0 when WIDTH=32). size=11 with WIDTH=32 is also a fault.
  - A fault performs no RAM access and no write.
  - The response follows the same latency, with misalign=1 and rd=0.
- Store: only the addressed bytes are written. wd LSBs are shifted into the lane position; the other bytes of the word are unchanged.
- Load: the addressed bytes are extracted from the word, right-justified, then sign- or zero-extended to WIDTH. rd is registered at the access edge and holds its value until the next access edge or reset. Store responses return rd=0.
- Inputs are ignored while req_ready=0, even if req_valid=1.
- Reset mid-operation: a pending access in BUSY is dropped (no write occurs), and no rsp_valid is produced. If reset coincides with an access edge, reset wins.

Decomposition:
- Package dmem_pkg holds:
  - enum size_t {SZ_B, SZ_H, SZ_W, SZ_D}
  - enum state_t {IDLE, BUSY, RESP}
  - function is_misaligned(size, lane, WIDTH)
- Sub-module dmem_array: word array with per-byte write enables and a combinational read port. dmem_bus wraps it with the FSM, alignment and extension logic.

Test Plan:
WIDTH=32, SIZE=64 unless noted.
- WAIT=0: store word 0xDEADBEEF at a=0x10, then load word at 0x10 -> rd=0xDEADBEEF, misalign=0. rsp_valid is high exactly one cycle, during the 2nd cycle after the accept edge. req_ready=0 during BUSY and RESP.
- Store word 0xDEADBEEF at 0x10, then store byte wd=0x80 at 0x13:
  - load byte at 0x13 -> 0xFFFFFF80
  - load byte unsigned at 0x13 -> 0x00000080
  - load word at 0x10 -> 0x80ADBEEF
- Store word 0 at 0x20, then store half wd=0xF234 at 0x22:
  - load half at 0x22 -> 0xFFFFF234
  - load half unsigned at 0x22 -> 0x0000F234
  - load word at 0x20 -> 0xF2340000
- Misaligned requests:
  - load word at 0x11 -> misalign=1, rd=0
  - store half at 0x13 with wd=0xFFFF -> misalign=1, and a following load word at 0x10 is unchanged
  - size=11 -> misalign=1
- WAIT=3: request accepted at E0 -> rsp_valid high only between E4 and E5. A second req_valid held high throughout is accepted only after RESP ends, in IDLE.
- Store word 0x11111111 at 0x0, then issue a store of 0x22222222 and assert reset while in BUSY -> no response pulse, and a later load word at 0x100 (wraps to 0x0) returns 0x11111111.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and the alignment rule for the dmem_bus data memory.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Dword accesses only exist on the 64-bit variant; on 32-bit they always fault.
  function automatic logic is_misaligned(input size_t sz, input logic [2:0] lane,
                                         input int width);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lane[0];
      SZ_W:    bad = (lane[1:0] != 2'b00);
      default: bad = (width == 32) ? 1'b1 : (lane != 3'b000);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM with per-byte write enables and a combinational read.
module dmem_array #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64
) (
  input  logic                    clk,
  input  logic [WIDTH/8-1:0]      be,
  input  logic [$clog2(SIZE)-1:0] idx,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_bus.sv
// Request/response data memory: captures one request, waits WAIT cycles,
// performs an aligned sub-word access and returns a one-cycle response.
module dmem_bus
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64,
  parameter int WAIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             unsigned_ld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] wd,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rd,
  output logic             misalign
);

  localparam int NB   = WIDTH / 8;
  localparam int ALSB = $clog2(NB);
  localparam int AW   = $clog2(SIZE);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  size_t            size_q, size_d;
  logic             uns_q, uns_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [ALSB-1:0]  lane_q, lane_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             mis_q, mis_d;

  logic [NB-1:0]    be, be_wr;
  logic [7:0]       mask8, be_full;
  logic [WIDTH-1:0] wdata, rdata, sh, ext;
  logic             fault;
  logic             unused_a;

  // Addresses wrap modulo the array size, so the upper bits are deliberately dropped.
  assign unused_a = ^a[WIDTH-1:ALSB+AW];

  assign fault = is_misaligned(size_q, 3'(lane_q), WIDTH);
  assign sh    = rdata >> {lane_q, 3'b000};

  always_comb begin
    mask8 = 8'h00;
    ext   = sh;
    case (size_q)
      SZ_B: begin
        mask8 = 8'h01;
        ext   = uns_q ? WIDTH'(sh[7:0]) : WIDTH'($signed(sh[7:0]));
      end
      SZ_H: begin
        mask8 = 8'h03;
        ext   = uns_q ? WIDTH'(sh[15:0]) : WIDTH'($signed(sh[15:0]));
      end
      SZ_W: begin
        mask8 = 8'h0F;
        ext   = uns_q ? WIDTH'(sh[31:0]) : WIDTH'($signed(sh[31:0]));
      end
      default: begin
        mask8 = 8'hFF;
        ext   = sh;
      end
    endcase
  end

  assign be_full = mask8 << lane_q;
  assign wdata   = wd_q << {lane_q, 3'b000};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    mis_d   = mis_q;
    be      = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = we;
          size_d  = size_t'(size);
          uns_d   = unsigned_ld;
          idx_d   = a[ALSB+AW-1:ALSB];
          lane_d  = a[ALSB-1:0];
          wd_d    = wd;
          cnt_d   = 3'(WAIT);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = RESP;
          mis_d   = fault;
          rd_d    = '0;
          if (!fault) begin
            if (we_q) be = be_full[NB-1:0];
            else      rd_d = ext;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset must win over a coinciding access edge, so the write strobe is gated too.
  assign be_wr = reset ? '0 : be;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      lane_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
    end
  end

  dmem_array #(.WIDTH(WIDTH), .SIZE(SIZE)) u_array (
    .clk   (clk),
    .be    (be_wr),
    .idx   (idx_q),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rd        = rd_q;
  assign misalign  = mis_q;

endmodule

// File: tb/tb_dmem_bus.sv
// Directed bench for dmem_bus: one WAIT=0 instance for function, one WAIT=3 for timing.
module tb_dmem_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid0 = 1'b0, req_valid3 = 1'b0;
  logic        we = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] a = '0, wd = '0;
  logic        req_ready0, rsp_valid0, misalign0;
  logic        req_ready3, rsp_valid3, misalign3;
  logic [31:0] rd0, rd3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_bus #(.WIDTH(32), .SIZE(64), .WAIT(0)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .we(we), .size(size), .unsigned_ld(unsigned_ld), .a(a), .wd(wd),
    .rsp_valid(rsp_valid0), .rd(rd0), .misalign(misalign0));

  dmem_bus #(.WIDTH(32), .SIZE(64), .WAIT(3)) u3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .we(we), .size(size), .unsigned_ld(unsigned_ld), .a(a), .wd(wd),
    .rsp_valid(rsp_valid3), .rd(rd3), .misalign(misalign3));

  // Issue one request to u0 from a negedge and follow it to the end of its response.
  task automatic op(input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] addr, input logic [31:0] data,
                    output logic [31:0] r, output logic m, output int lat,
                    output int width, output bit ready_bad);
    r = 'x; m = 1'bx; lat = -1; width = 0; ready_bad = 0;
    we = w; size = sz; unsigned_ld = u; a = addr; wd = data;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (rsp_valid0) begin
        if (lat < 0) begin
          lat = n; r = rd0; m = misalign0;
        end
        width++;
        if (req_ready0) ready_bad = 1;
      end else if (lat >= 0) begin
        break;
      end else if (req_ready0) begin
        ready_bad = 1;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0 || rd0 !== 32'h0 || misalign0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_u0: ready=%b rsp=%b rd=%h mis=%b, required 1 0 00000000 0",
               req_ready0, rsp_valid0, rd0, misalign0);
    end
    checks++;
    if (req_ready3 !== 1'b1 || rsp_valid3 !== 1'b0 || rd3 !== 32'h0 || misalign3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_u3: ready=%b rsp=%b rd=%h mis=%b, required 1 0 00000000 0",
               req_ready3, rsp_valid3, rd3, misalign3);
    end
  endtask

  task automatic test_word;
    logic [31:0] r; logic m; int lat, wdt; bit rb;
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'h0 || m !== 1'b0 || lat !== 2 || wdt !== 1 || rb) begin
      failures++;
      $display("FAIL store_word: rd=%h mis=%b lat=%0d width=%0d ready_bad=%0d, required 0 0 2 1 0",
               r, m, lat, wdt, rb);
    end
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'hDEADBEEF || m !== 1'b0 || lat !== 2 || wdt !== 1 || rb) begin
      failures++;
      $display("FAIL load_word: rd=%h mis=%b lat=%0d width=%0d ready_bad=%0d, required deadbeef 0 2 1 0",
               r, m, lat, wdt, rb);
    end
    checks++;
    if (rd0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_hold: rd=%h, required deadbeef", rd0);
    end
  endtask

  task automatic test_byte;
    logic [31:0] r; logic m; int lat, wdt; bit rb;
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r, m, lat, wdt, rb);
    op(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, r, m, lat, wdt, rb);
    op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'hFFFFFF80 || m !== 1'b0) begin
      failures++;
      $display("FAIL load_byte_signed: rd=%h mis=%b, required ffffff80 0", r, m);
    end
    op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'h00000080 || m !== 1'b0) begin
      failures++;
      $display("FAIL load_byte_unsigned: rd=%h mis=%b, required 00000080 0", r, m);
    end
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'h80ADBEEF || m !== 1'b0) begin
      failures++;
      $display("FAIL byte_merge_word: rd=%h mis=%b, required 80adbeef 0", r, m);
    end
  endtask

  task automatic test_half;
    logic [31:0] r; logic m; int lat, wdt; bit rb;
    op(1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000, r, m, lat, wdt, rb);
    op(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000F234, r, m, lat, wdt, rb);
    op(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'hFFFFF234 || m !== 1'b0) begin
      failures++;
      $display("FAIL load_half_signed: rd=%h mis=%b, required fffff234 0", r, m);
    end
    op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'h0000F234 || m !== 1'b0) begin
      failures++;
      $display("FAIL load_half_unsigned: rd=%h mis=%b, required 0000f234 0", r, m);
    end
    op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'hF2340000 || m !== 1'b0) begin
      failures++;
      $display("FAIL half_merge_word: rd=%h mis=%b, required f2340000 0", r, m);
    end
  endtask

  task automatic test_misalign;
    logic [31:0] r; logic m; int lat, wdt; bit rb;
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r, m, lat, wdt, rb);
    op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'h0 || m !== 1'b1 || lat !== 2 || wdt !== 1) begin
      failures++;
      $display("FAIL mis_load_word: rd=%h mis=%b lat=%0d width=%0d, required 0 1 2 1", r, m, lat, wdt);
    end
    op(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, r, m, lat, wdt, rb);
    checks++;
    if (m !== 1'b1 || r !== 32'h0) begin
      failures++;
      $display("FAIL mis_store_half: rd=%h mis=%b, required 0 1", r, m);
    end
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'hDEADBEEF || m !== 1'b0) begin
      failures++;
      $display("FAIL mis_no_write: rd=%h mis=%b, required deadbeef 0", r, m);
    end
    op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'h0 || m !== 1'b1) begin
      failures++;
      $display("FAIL mis_dword: rd=%h mis=%b, required 0 1", r, m);
    end
    op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'h0000DEAD || m !== 1'b0) begin
      failures++;
      $display("FAIL aligned_half_hi: rd=%h mis=%b, required 0000dead 0", r, m);
    end
  endtask

  // req_valid held high on the WAIT=3 instance: accepts are WAIT+3 cycles apart.
  task automatic test_wait;
    int rsp_at [$];
    int first_ready;
    we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; a = 32'h0; wd = 32'h12345678;
    first_ready = -1;
    @(negedge clk);
    req_valid3 = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (rsp_valid3) rsp_at.push_back(n);
      if (req_ready3 && first_ready < 0) first_ready = n;
    end
    req_valid3 = 1'b0;
    checks++;
    if (rsp_at.size() !== 2 || rsp_at[0] !== 5 || rsp_at[1] !== 11) begin
      failures++;
      $display("FAIL wait3_rsp: pulses=%0d first=%0d second=%0d, required 2 5 11",
               rsp_at.size(), (rsp_at.size() > 0) ? rsp_at[0] : -1,
               (rsp_at.size() > 1) ? rsp_at[1] : -1);
    end
    checks++;
    if (first_ready !== 6) begin
      failures++;
      $display("FAIL wait3_ready: first ready at %0d, required 6", first_ready);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; logic m; int lat, wdt; bit rb;
    int pulses;
    op(1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111, r, m, lat, wdt, rb);
    we = 1'b1; size = 2'b10; a = 32'h0; wd = 32'h22222222;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rsp_valid0) pulses++;
    end
    checks++;
    if (pulses !== 0 || req_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_rsp: pulses=%0d ready=%b, required 0 1", pulses, req_ready0);
    end
    op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, m, lat, wdt, rb);
    checks++;
    if (r !== 32'h11111111 || m !== 1'b0 || lat !== 2) begin
      failures++;
      $display("FAIL reset_mid_nowrite: rd=%h mis=%b lat=%0d, required 11111111 0 2", r, m, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_wait();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
